// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port of the pipeline memory stage.
// The stage side is the master; the memory model or controller is the slave.
interface mem_stage_if;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [15:0] mem_addr_o;
   logic [15:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [15:0] mem_rdata_i;

   modport master (
      output mem_req_o,
      output mem_we_o,
      output mem_addr_o,
      output mem_wdata_o,
      input  mem_ack_i,
      input  mem_rdata_i
   );

   modport slave (
      input  mem_req_o,
      input  mem_we_o,
      input  mem_addr_o,
      input  mem_wdata_o,
      output mem_ack_i,
      output mem_rdata_i
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM and MEM/WB registers, one outstanding load/store
// at a time with an upstream stall, and the EX/MEM forwarding triples.
module mem_stage (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        valid_i,
   input  logic [15:0] alures_i,
   input  logic [15:0] storedata_i,
   input  logic [3:0]  regdst_i,
   input  logic        regwrite_i,
   input  logic        memread_i,
   input  logic        memwrite_i,
   output logic        stall_o,
   mem_stage_if.master mem,
   output logic [3:0]  exregdst_o,
   output logic        exregwrite_o,
   output logic [15:0] exregdata_o,
   output logic [3:0]  memregdst_o,
   output logic        memregwrite_o,
   output logic [15:0] memregdata_o
);

   localparam logic [3:0] NO_REG = 4'b1111;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   state_e      state_q, state_d;

   logic        ex_v_q,   ex_v_d;
   logic [3:0]  ex_dst_q, ex_dst_d;
   logic        ex_rw_q,  ex_rw_d;
   logic        ex_rd_q,  ex_rd_d;
   logic        ex_wr_q,  ex_wr_d;
   logic [15:0] ex_res_q, ex_res_d;
   logic [15:0] ex_sd_q,  ex_sd_d;

   logic [3:0]  wb_dst_q,  wb_dst_d;
   logic        wb_rw_q,   wb_rw_d;
   logic [15:0] wb_data_q, wb_data_d;

   logic        in_wait;

   always_comb begin
      state_d   = state_q;
      ex_v_d    = ex_v_q;
      ex_dst_d  = ex_dst_q;
      ex_rw_d   = ex_rw_q;
      ex_rd_d   = ex_rd_q;
      ex_wr_d   = ex_wr_q;
      ex_res_d  = ex_res_q;
      ex_sd_d   = ex_sd_q;
      wb_dst_d  = wb_dst_q;
      wb_rw_d   = wb_rw_q;
      wb_data_d = wb_data_q;

      case (state_q)
         ST_RUN: begin
            ex_v_d   = valid_i;
            ex_dst_d = regdst_i;
            // Stores never claim a register, so the EX slot never forwards one.
            ex_rw_d  = valid_i & regwrite_i & ~memwrite_i;
            ex_rd_d  = valid_i & memread_i;
            ex_wr_d  = valid_i & memwrite_i;
            ex_res_d = alures_i;
            ex_sd_d  = storedata_i;

            wb_dst_d  = ex_dst_q;
            wb_rw_d   = ex_v_q & ex_rw_q & ~ex_wr_q;
            wb_data_d = ex_res_q;

            if (valid_i & (memread_i | memwrite_i)) begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (mem.mem_ack_i) begin
               wb_dst_d  = ex_dst_q;
               wb_rw_d   = ex_rw_q & ex_rd_q;
               wb_data_d = ex_rd_q ? mem.mem_rdata_i : ex_res_q;
               // Emptying EX/MEM here produces the single bubble after each access.
               ex_v_d    = 1'b0;
               ex_rw_d   = 1'b0;
               ex_rd_d   = 1'b0;
               ex_wr_d   = 1'b0;
               state_d   = ST_RUN;
            end
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= ST_RUN;
         ex_v_q    <= 1'b0;
         ex_dst_q  <= 4'b0000;
         ex_rw_q   <= 1'b0;
         ex_rd_q   <= 1'b0;
         ex_wr_q   <= 1'b0;
         ex_res_q  <= 16'h0000;
         ex_sd_q   <= 16'h0000;
         wb_dst_q  <= 4'b0000;
         wb_rw_q   <= 1'b0;
         wb_data_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         ex_v_q    <= ex_v_d;
         ex_dst_q  <= ex_dst_d;
         ex_rw_q   <= ex_rw_d;
         ex_rd_q   <= ex_rd_d;
         ex_wr_q   <= ex_wr_d;
         ex_res_q  <= ex_res_d;
         ex_sd_q   <= ex_sd_d;
         wb_dst_q  <= wb_dst_d;
         wb_rw_q   <= wb_rw_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign in_wait = (state_q == ST_WAIT);

   // Memory port is driven straight from flops, so it is glitch-free and stable until ack.
   assign stall_o         = in_wait;
   assign mem.mem_req_o   = in_wait;
   assign mem.mem_we_o    = in_wait & ex_wr_q;
   assign mem.mem_addr_o  = in_wait ? ex_res_q : 16'h0000;
   assign mem.mem_wdata_o = in_wait ? ex_sd_q  : 16'h0000;

   assign exregdst_o   = ex_dst_q;
   assign exregwrite_o = ex_v_q & ex_rw_q & ~ex_rd_q & (ex_dst_q != NO_REG);
   assign exregdata_o  = ex_res_q;

   assign memregdst_o   = wb_dst_q;
   assign memregwrite_o = wb_rw_q & (wb_dst_q != NO_REG);
   assign memregdata_o  = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cycle table, reset corners and
// randomized traffic against a transaction-level reference model.
module tb_mem_stage;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        valid_i;
   logic [15:0] alures_i;
   logic [15:0] storedata_i;
   logic [3:0]  regdst_i;
   logic        regwrite_i;
   logic        memread_i;
   logic        memwrite_i;
   logic        stall_o;
   logic [3:0]  exregdst_o;
   logic        exregwrite_o;
   logic [15:0] exregdata_o;
   logic [3:0]  memregdst_o;
   logic        memregwrite_o;
   logic [15:0] memregdata_o;

   mem_stage_if mem_bus ();

   mem_stage dut (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .valid_i       (valid_i),
      .alures_i      (alures_i),
      .storedata_i   (storedata_i),
      .regdst_i      (regdst_i),
      .regwrite_i    (regwrite_i),
      .memread_i     (memread_i),
      .memwrite_i    (memwrite_i),
      .stall_o       (stall_o),
      .mem           (mem_bus.master),
      .exregdst_o    (exregdst_o),
      .exregwrite_o  (exregwrite_o),
      .exregdata_o   (exregdata_o),
      .memregdst_o   (memregdst_o),
      .memregwrite_o (memregwrite_o),
      .memregdata_o  (memregdata_o)
   );

   always #5 clk_i = ~clk_i;

   // {stall, req, we, addr, wdata, exw, exdst, exdata, memw, memdst, memdata}
   typedef logic [76:0] obs_t;

   typedef struct {
      logic        v;
      logic [3:0]  dst;
      logic        rw, rd, wr;
      logic [15:0] res, sd;
      logic        ack;
      logic [15:0] rdata;
      obs_t        exp;
   } vec_t;

   int total = 0;
   int bad   = 0;

   function automatic obs_t observe();
      return {stall_o, mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o,
              mem_bus.mem_wdata_o, exregwrite_o, exregdst_o, exregdata_o,
              memregwrite_o, memregdst_o, memregdata_o};
   endfunction

   function automatic obs_t pk(logic st, logic rq, logic we, logic [15:0] ad, logic [15:0] wd,
                               logic exw, logic [3:0] exd, logic [15:0] exr,
                               logic mw, logic [3:0] md, logic [15:0] mr);
      return {st, rq, we, ad, wd, exw, exd, exr, mw, md, mr};
   endfunction

   function automatic vec_t mkv(logic v, logic [3:0] dst, logic rw, logic rd, logic wr,
                                logic [15:0] res, logic [15:0] sd, logic ack,
                                logic [15:0] rdata, obs_t exp);
      vec_t t;
      t.v = v; t.dst = dst; t.rw = rw; t.rd = rd; t.wr = wr;
      t.res = res; t.sd = sd; t.ack = ack; t.rdata = rdata; t.exp = exp;
      return t;
   endfunction

   task automatic check(input string name, input obs_t got, input obs_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] dst, input logic rw, input logic rd,
                        input logic wr, input logic [15:0] res, input logic [15:0] sd,
                        input logic ack, input logic [15:0] rdata);
      valid_i = v; regdst_i = dst; regwrite_i = rw; memread_i = rd; memwrite_i = wr;
      alures_i = res; storedata_i = sd;
      mem_bus.mem_ack_i = ack; mem_bus.mem_rdata_i = rdata;
   endtask

   task automatic drive_random();
      logic [1:0] op;
      op = 2'($urandom_range(0, 9) < 3 ? $urandom_range(1, 2) : 0);
      drive(($urandom_range(0, 9) < 7), 4'($urandom), 1'($urandom), op[0], op[1],
            16'($urandom), 16'($urandom), ($urandom_range(0, 9) < 4), 16'($urandom));
   endtask

   // Reference model: one instruction in flight, results retire into the writeback slot.
   typedef struct packed {
      logic        v;
      logic        w;
      logic        ld;
      logic        st;
      logic [3:0]  dst;
      logic [15:0] res;
      logic [15:0] sd;
   } instr_t;

   typedef struct packed {
      logic [3:0]  dst;
      logic        w;
      logic [15:0] data;
   } result_t;

   instr_t  m_ex;
   result_t m_wb;
   logic    m_busy;
   int      n_mem_ops;

   function automatic result_t retire(instr_t ins, logic [15:0] rdata);
      result_t r;
      r.dst  = ins.dst;
      r.w    = ins.v & ins.w;
      r.data = ins.ld ? rdata : ins.res;
      return r;
   endfunction

   task automatic model_reset();
      m_ex = '0; m_wb = '0; m_busy = 1'b0;
   endtask

   task automatic model_step();
      if (!m_busy) begin
         m_wb     = retire(m_ex, 16'h0000);
         m_ex.v   = valid_i;
         m_ex.w   = valid_i & regwrite_i & ~memwrite_i;
         m_ex.ld  = valid_i & memread_i;
         m_ex.st  = valid_i & memwrite_i;
         m_ex.dst = regdst_i;
         m_ex.res = alures_i;
         m_ex.sd  = storedata_i;
         m_busy   = m_ex.ld | m_ex.st;
      end else if (mem_bus.mem_ack_i) begin
         m_wb = retire(m_ex, mem_bus.mem_rdata_i);
         n_mem_ops++;
         $display("mem %s addr=%h dst=%0d wdata=%h result=%h write=%0b",
                  m_ex.st ? "st" : "ld", m_ex.res, m_ex.dst, m_ex.sd, m_wb.data, m_wb.w);
         m_ex.v = 1'b0; m_ex.w = 1'b0; m_ex.ld = 1'b0; m_ex.st = 1'b0;
         m_busy = 1'b0;
      end
   endtask

   function automatic obs_t model_expect();
      return pk(m_busy, m_busy, m_busy & m_ex.st,
                m_busy ? m_ex.res : 16'h0000, m_busy ? m_ex.sd : 16'h0000,
                m_ex.v & m_ex.w & ~m_ex.ld & (m_ex.dst != 4'hF), m_ex.dst, m_ex.res,
                m_wb.w & (m_wb.dst != 4'hF), m_wb.dst, m_wb.data);
   endfunction

   vec_t vecs[20];

   initial begin
      // Each row: inputs held across one edge, then the expected outputs after it.
      vecs[0]  = mkv(1, 4'd3, 1, 0, 0, 16'h1234, 16'h0000, 0, 16'h0000, pk(0,0,0,16'h0000,16'h0000, 1,4'd3,16'h1234, 0,4'd0,16'h0000));
      vecs[1]  = mkv(0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, pk(0,0,0,16'h0000,16'h0000, 0,4'd0,16'h0000, 1,4'd3,16'h1234));
      vecs[2]  = mkv(0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, pk(0,0,0,16'h0000,16'h0000, 0,4'd0,16'h0000, 0,4'd0,16'h0000));
      vecs[3]  = mkv(1, 4'd5, 1, 1, 0, 16'h0040, 16'h0000, 0, 16'h0000, pk(1,1,0,16'h0040,16'h0000, 0,4'd5,16'h0040, 0,4'd0,16'h0000));
      vecs[4]  = mkv(1, 4'd9, 1, 0, 0, 16'h1111, 16'h0000, 0, 16'h0000, pk(1,1,0,16'h0040,16'h0000, 0,4'd5,16'h0040, 0,4'd0,16'h0000));
      vecs[5]  = mkv(1, 4'd9, 1, 0, 0, 16'h1111, 16'h0000, 0, 16'h0000, pk(1,1,0,16'h0040,16'h0000, 0,4'd5,16'h0040, 0,4'd0,16'h0000));
      vecs[6]  = mkv(1, 4'd9, 1, 0, 0, 16'h1111, 16'h0000, 1, 16'hBEEF, pk(0,0,0,16'h0000,16'h0000, 0,4'd5,16'h0040, 1,4'd5,16'hBEEF));
      vecs[7]  = mkv(1, 4'd9, 1, 0, 0, 16'h1111, 16'h0000, 0, 16'h0000, pk(0,0,0,16'h0000,16'h0000, 1,4'd9,16'h1111, 0,4'd5,16'h0040));
      vecs[8]  = mkv(0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, pk(0,0,0,16'h0000,16'h0000, 0,4'd0,16'h0000, 1,4'd9,16'h1111));
      vecs[9]  = mkv(1, 4'd2, 1, 0, 1, 16'h0010, 16'hA5A5, 0, 16'h0000, pk(1,1,1,16'h0010,16'hA5A5, 0,4'd2,16'h0010, 0,4'd0,16'h0000));
      vecs[10] = mkv(0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, pk(0,0,0,16'h0000,16'h0000, 0,4'd2,16'h0010, 0,4'd2,16'h0010));
      vecs[11] = mkv(0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, pk(0,0,0,16'h0000,16'h0000, 0,4'd0,16'h0000, 0,4'd2,16'h0010));
      vecs[12] = mkv(1, 4'hF, 1, 0, 0, 16'h5555, 16'h0000, 0, 16'h0000, pk(0,0,0,16'h0000,16'h0000, 0,4'hF,16'h5555, 0,4'd0,16'h0000));
      vecs[13] = mkv(0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, pk(0,0,0,16'h0000,16'h0000, 0,4'd0,16'h0000, 0,4'hF,16'h5555));
      vecs[14] = mkv(1, 4'd6, 1, 1, 0, 16'h0080, 16'h0000, 0, 16'h0000, pk(1,1,0,16'h0080,16'h0000, 0,4'd6,16'h0080, 0,4'd0,16'h0000));
      vecs[15] = mkv(1, 4'd7, 1, 0, 0, 16'h0077, 16'h0000, 1, 16'h1357, pk(0,0,0,16'h0000,16'h0000, 0,4'd6,16'h0080, 1,4'd6,16'h1357));
      vecs[16] = mkv(1, 4'd7, 1, 0, 0, 16'h0077, 16'h0000, 1, 16'hFFFF, pk(0,0,0,16'h0000,16'h0000, 1,4'd7,16'h0077, 0,4'd6,16'h0080));
      vecs[17] = mkv(1, 4'd8, 1, 1, 0, 16'h00A0, 16'h0000, 0, 16'h0000, pk(1,1,0,16'h00A0,16'h0000, 0,4'd8,16'h00A0, 1,4'd7,16'h0077));
      vecs[18] = mkv(0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h2468, pk(0,0,0,16'h0000,16'h0000, 0,4'd8,16'h00A0, 1,4'd8,16'h2468));
      vecs[19] = mkv(0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, pk(0,0,0,16'h0000,16'h0000, 0,4'd0,16'h0000, 0,4'd8,16'h00A0));

      n_mem_ops = 0;

      // Reset held while inputs toggle randomly.
      rstn_i = 1'b0;
      drive_random();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         check($sformatf("reset_hold%0d", i), observe(), '0);
         $display("reset cycle %0d obs=%h", i, observe());
         drive_random();
      end
      drive(0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
      rstn_i = 1'b1;

      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].v, vecs[i].dst, vecs[i].rw, vecs[i].rd, vecs[i].wr,
               vecs[i].res, vecs[i].sd, vecs[i].ack, vecs[i].rdata);
         @(negedge clk_i);
         check($sformatf("vec%0d", i), observe(), vecs[i].exp);
         $display("vec %0d v=%0b dst=%0d rd=%0b wr=%0b res=%h ack=%0b obs=%h",
                  i, vecs[i].v, vecs[i].dst, vecs[i].rd, vecs[i].wr, vecs[i].res,
                  vecs[i].ack, observe());
      end

      // Reset asserted mid-WAIT must drop the request before the next edge.
      drive(1, 4'd4, 1, 1, 0, 16'h0300, 16'h0000, 0, 16'h0000);
      @(negedge clk_i);
      check("midwait_enter", 77'({stall_o, mem_bus.mem_req_o}), 77'(2'b11));
      drive(0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'hDEAD);
      #1 rstn_i = 1'b0;
      #1 check("midwait_reset_async", observe(), '0);
      $display("midwait reset obs=%h", observe());
      @(negedge clk_i);
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
      check("after_reset_late_ack", observe(), '0);
      @(negedge clk_i);
      check("after_reset_idle", observe(), '0);

      // Randomized traffic against the reference model, starting from a clean reset.
      rstn_i = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         check($sformatf("rand%0d", c), observe(), model_expect());
         drive_random();
         @(posedge clk_i);
         model_step();
         @(negedge clk_i);
      end
      check("rand_final", observe(), model_expect());
      $display("random phase retired %0d memory ops", n_mem_ops);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
